// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed seven-segment scan controller for DIGITS
// common-node digits.
//
// Features:
//   - clock-enable slot timer
//   - per-digit skip
//   - anti-ghosting blank window
//   - 4-bit PWM brightness
//   - frame strobe
//
// Optional feature: define FND_SHADOW_EN to latch the pattern inputs into
// shadow registers once per frame. This gives tear-free frames.
//
// Parameters:
//   DIGITS    - number of digits scanned (1..16)
//   SCAN_DIV  - clk cycles per digit slot (>= 32)
//   BLANK_CYC - dead cycles at the start of each slot (< SCAN_DIV)
//
// Ports:
//   clk, rst_n    - clock and synchronous active-low reset
//   i_digit_seg   - packed {a..g} patterns; digit k at [7k+6:7k]
//   i_dp          - per-digit decimal point
//   i_digit_en    - per-digit scan enable (0 = skipped)
//   i_bright      - brightness: 0 dark, 1..14 duty/16, 15 full on
//   o_seg         - segments of the active digit
//   o_seg_dp      - decimal point of the active digit
//   o_seg_enb     - active-low digit enables, at most one low
//   o_frame_tick  - one-cycle pulse when the scan wraps to a new frame
module fnd_scan_ctrl #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned SCAN_DIV  = 25000,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7*DIGITS-1:0]   i_digit_seg,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_digit_en,
    input  logic [3:0]            i_bright,
    output logic [6:0]            o_seg,
    output logic                  o_seg_dp,
    output logic [DIGITS-1:0]     o_seg_enb,
    output logic                  o_frame_tick
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned PWM_W = 4;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [PWM_W-1:0] BRIGHT_FULL = PWM_W'(15);

    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [PWM_W-1:0]        pwm_cnt_q, pwm_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wrap_q, wrap_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [DIGITS-1:0]       enb_q, enb_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_end_c;
    logic                    slot_start_c;
    logic [IDX_W-1:0]        nxt_idx_c;
    logic                    nxt_wrap_c;
    logic                    nxt_found_c;
    logic                    cur_en_c;
    logic                    digit_on_c;
    logic [SEG_W*DIGITS-1:0] src_seg_c;
    logic [DIGITS-1:0]       src_dp_c;
    logic [SEG_W-1:0]        sel_seg_c;
    logic                    sel_dp_c;

    assign slot_end_c   = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
    assign slot_start_c = (slot_cnt_q == '0);

    // Circular search for the next enabled digit after idx_q.
    // Sets the wrap flag when the search crosses from DIGITS-1 to 0.
    always_comb begin
        nxt_idx_c   = idx_q;
        nxt_wrap_c  = 1'b1;
        nxt_found_c = 1'b0;
        for (int unsigned i = 1; i <= DIGITS; i++) begin
            int unsigned cand;
            logic        crossed;
            cand    = 32'(idx_q) + i;
            crossed = (cand >= DIGITS);
            if (crossed) begin
                cand = cand - DIGITS;
            end
            if (!nxt_found_c && i_digit_en[IDX_W'(cand)]) begin
                nxt_found_c = 1'b1;
                nxt_idx_c   = IDX_W'(cand);
                nxt_wrap_c  = crossed;
            end
        end
    end

`ifdef FND_SHADOW_EN
    logic [SEG_W*DIGITS-1:0] shadow_seg_q, shadow_seg_d;
    logic [DIGITS-1:0]       shadow_dp_q, shadow_dp_d;

    // Capture on the frame-tick edge.
    // The first digit of the new frame bypasses the shadow so that it
    // already shows the fresh copy.
    always_comb begin
        shadow_seg_d = shadow_seg_q;
        shadow_dp_d  = shadow_dp_q;
        src_seg_c    = shadow_seg_q;
        src_dp_c     = shadow_dp_q;
        if (frame_tick_d) begin
            shadow_seg_d = i_digit_seg;
            shadow_dp_d  = i_dp;
            src_seg_c    = i_digit_seg;
            src_dp_c     = i_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_seg_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            shadow_seg_q <= shadow_seg_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end
`else
    always_comb begin
        src_seg_c = i_digit_seg;
        src_dp_c  = i_dp;
    end
`endif

    // Pattern and enable bit of the currently selected digit.
    always_comb begin
        sel_seg_c = '0;
        sel_dp_c  = 1'b0;
        cur_en_c  = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_seg_c = src_seg_c[SEG_W*k +: SEG_W];
                sel_dp_c  = src_dp_c[k];
                cur_en_c  = i_digit_en[k];
            end
        end
    end

    assign digit_on_c = cur_en_c
                     && (slot_cnt_q >= CNT_W'(BLANK_CYC))
                     && ((i_bright == BRIGHT_FULL) || (pwm_cnt_q < i_bright));

    // Next-state logic for the timers, the digit index and all outputs.
    // Segments load on the first cycle of a slot, while the enables are
    // still inside the blank window, so the previous digit never ghosts.
    always_comb begin
        slot_cnt_d   = slot_end_c ? '0 : slot_cnt_q + CNT_W'(1);
        pwm_cnt_d    = pwm_cnt_q + PWM_W'(1);
        idx_d        = idx_q;
        wrap_d       = wrap_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        enb_d        = '1;
        frame_tick_d = 1'b0;

        if (slot_end_c) begin
            idx_d  = nxt_idx_c;
            wrap_d = nxt_wrap_c;
        end else if (slot_start_c) begin
            wrap_d = 1'b0;
        end

        if (slot_start_c) begin
            seg_d        = sel_seg_c;
            dp_d         = sel_dp_c;
            frame_tick_d = wrap_q;
        end

        for (int unsigned k = 0; k < DIGITS; k++) begin
            enb_d[k] = ~(digit_on_c && (idx_q == IDX_W'(k)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            pwm_cnt_q    <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            enb_q        <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            idx_q        <= idx_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            enb_q        <= enb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_seg_dp     = dp_q;
    assign o_seg_enb    = enb_q;
    assign o_frame_tick = frame_tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Testbench for fnd_scan_ctrl with DIGITS=4, SCAN_DIV=40, BLANK_CYC=8.
// Per-slot expectations are queued as stimulus is applied. Each slot is then
// observed for SCAN_DIV cycles and its summary is checked against the queue.
module tb_fnd_scan_ctrl;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCAN_DIV  = 40;
    localparam int unsigned BLANK_CYC = 8;
`ifdef FND_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        logic [3:0] on_val;
        int         on_cnt;
        int         lead;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [7*DIGITS-1:0]   i_digit_seg;
    logic [DIGITS-1:0]     i_dp;
    logic [DIGITS-1:0]     i_digit_en;
    logic [3:0]            i_bright;
    logic [6:0]            o_seg;
    logic                  o_seg_dp;
    logic [DIGITS-1:0]     o_seg_enb;
    logic                  o_frame_tick;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    fnd_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_digit_seg  (i_digit_seg),
        .i_dp         (i_dp),
        .i_digit_en   (i_digit_en),
        .i_bright     (i_bright),
        .o_seg        (o_seg),
        .o_seg_dp     (o_seg_dp),
        .o_seg_enb    (o_seg_enb),
        .o_frame_tick (o_frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [6:0] seg, input logic dp, input logic tick,
                        input logic [3:0] on_val, input int on_cnt, input int lead);
        exp_t e;
        e.seg    = seg;
        e.dp     = dp;
        e.tick   = tick;
        e.on_val = on_val;
        e.on_cnt = on_cnt;
        e.lead   = lead;
        sb_q.push_back(e);
    endtask

    // Watch one full slot, from its first cycle up to and including the
    // first cycle of the next slot (the last enable of the slot lands there).
    task automatic observe_slot(input int n);
        exp_t       e;
        logic [6:0] seg0;
        logic       dp0;
        logic       tick0;
        logic       stable;
        logic [3:0] on_val;
        int         on_cnt;
        int         tick_cnt;
        int         lead;
        logic       lead_done;
        seg0 = '0; dp0 = 1'b0; tick0 = 1'b0; stable = 1'b1;
        on_val = 4'hF; on_cnt = 0; tick_cnt = 0; lead = 0; lead_done = 1'b0;
        for (int c = 0; c < int'(SCAN_DIV); c++) begin
            step();
            if (c == 0) begin
                seg0  = o_seg;
                dp0   = o_seg_dp;
                tick0 = o_frame_tick;
            end else if (c < int'(SCAN_DIV) - 1) begin
                if (o_seg !== seg0 || o_seg_dp !== dp0) stable = 1'b0;
            end
            if (o_frame_tick === 1'b1) tick_cnt++;
            if (o_seg_enb !== 4'hF) begin
                on_cnt++;
                if (on_val === 4'hF) on_val = o_seg_enb;
                else if (o_seg_enb !== on_val) on_val = 4'hX;
            end
            if (!lead_done && o_seg_enb === 4'hF) lead++;
            else lead_done = 1'b1;
        end
        if (sb_q.size() == 0) begin
            check($sformatf("slot%0d_sb_empty", n), 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("slot%0d_seg", n),      32'(seg0),     32'(e.seg));
            check($sformatf("slot%0d_dp", n),       32'(dp0),      32'(e.dp));
            check($sformatf("slot%0d_stable", n),   32'(stable),   32'd1);
            check($sformatf("slot%0d_tick", n),     32'(tick0),    32'(e.tick));
            check($sformatf("slot%0d_tick_cnt", n), 32'(tick_cnt), 32'(e.tick));
            check($sformatf("slot%0d_enb", n),      32'(on_val),   32'(e.on_val));
            check($sformatf("slot%0d_on_cnt", n),   32'(on_cnt),   32'(e.on_cnt));
            if (e.lead >= 0) begin
                check($sformatf("slot%0d_lead", n), 32'(lead), 32'(e.lead));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg"},  32'(o_seg),        32'd0);
        check({tag, "_dp"},   32'(o_seg_dp),     32'd0);
        check({tag, "_enb"},  32'(o_seg_enb),    32'hF);
        check({tag, "_tick"}, 32'(o_frame_tick), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        i_digit_seg = {7'h30, 7'h6D, 7'h79, 7'h7E};
        i_dp        = 4'b0100;
        i_digit_en  = 4'hF;
        i_bright    = 4'd15;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;

        // First frame: all digits, full brightness; no tick right after reset.
        push(SHADOW ? 7'h00 : 7'h7E, 1'b0, 1'b0, 4'b1110, 32, 8); observe_slot(0);
        push(SHADOW ? 7'h00 : 7'h79, 1'b0, 1'b0, 4'b1101, 32, 8); observe_slot(1);
        push(SHADOW ? 7'h00 : 7'h6D, SHADOW ? 1'b0 : 1'b1, 1'b0, 4'b1011, 32, 8); observe_slot(2);
        push(SHADOW ? 7'h00 : 7'h30, 1'b0, 1'b0, 4'b0111, 32, 8); observe_slot(3);
        push(7'h7E, 1'b0, 1'b1, 4'b1110, 32, 8); observe_slot(4);

        // Brightness 4/16 over a 32-cycle window gives 8 on-cycles; then dark.
        i_bright = 4'd4;
        push(7'h79, 1'b0, 1'b0, 4'b1101, 8, -1); observe_slot(5);
        i_bright = 4'd0;
        push(7'h6D, 1'b1, 1'b0, 4'hF, 0, 40); observe_slot(6);

        // Skip digits 1 and 3. Digit 3 was already chosen, so it is shown dark.
        i_bright   = 4'd15;
        i_digit_en = 4'b0101;
        push(7'h30, 1'b0, 1'b0, 4'hF, 0, 40); observe_slot(7);
        push(7'h7E, 1'b0, 1'b1, 4'b1110, 32, 8); observe_slot(8);
        push(7'h6D, 1'b1, 1'b0, 4'b1011, 32, 8); observe_slot(9);
        push(7'h7E, 1'b0, 1'b1, 4'b1110, 32, 8); observe_slot(10);

        // Mid-frame pattern change on digit 2.
        i_digit_seg = {7'h30, 7'h5B, 7'h79, 7'h7E};
        push(SHADOW ? 7'h6D : 7'h5B, 1'b1, 1'b0, 4'b1011, 32, 8); observe_slot(11);
        push(7'h7E, 1'b0, 1'b1, 4'b1110, 32, 8); observe_slot(12);
        push(7'h5B, 1'b1, 1'b0, 4'b1011, 32, 8); observe_slot(13);

        // No digits enabled: index holds and the tick fires every slot.
        i_digit_en = 4'h0;
        push(7'h7E, 1'b0, 1'b1, 4'hF, 0, 40); observe_slot(14);
        push(7'h7E, 1'b0, 1'b1, 4'hF, 0, 40); observe_slot(15);
        push(7'h7E, 1'b0, 1'b1, 4'hF, 0, 40); observe_slot(16);

        i_digit_en = 4'hF;
        push(7'h7E, 1'b0, 1'b1, 4'b1110, 32, 8); observe_slot(17);
        push(7'h79, 1'b0, 1'b0, 4'b1101, 32, 8); observe_slot(18);

        // Reset while digit 2 is shown at slot_cnt=20.
        for (int c = 0; c < 20; c++) step();
        check("mid_seg", 32'(o_seg),     32'h5B);
        check("mid_dp",  32'(o_seg_dp),  32'd1);
        check("mid_enb", 32'(o_seg_enb), 32'b1011);
        rst_n = 1'b0;
        step();
        check_reset_values("mid_reset");
        rst_n = 1'b1;
        push(SHADOW ? 7'h00 : 7'h7E, 1'b0, 1'b0, 4'b1110, 32, 8); observe_slot(19);
        push(SHADOW ? 7'h00 : 7'h79, 1'b0, 1'b0, 4'b1101, 32, 8); observe_slot(20);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
